// File: rtl/memory_master.sv
// Bus initiator for the 8-bit RAM port: one load/store at a time, IDLE -> ACCESS -> RELEASE.
// Latency: response pulse 4 cycles after acceptance with a 2-cycle memory; next accept 5 cycles later.
// Backpressure: req_ready only in IDLE; ACCESS waits on mem_ready (bounded when MEMORY_MASTER_TIMEOUT_EN is defined).
module memory_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   // The abort counter is 8 bits wide, so TIMEOUT must fit it and leave room for a real access.
   if (TIMEOUT < 3 || TIMEOUT > 255) begin : g_timeout_range
      $error("memory_master: TIMEOUT must be in 3..255");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              resp_valid_q, resp_valid_d;

`ifdef MEMORY_MASTER_TIMEOUT_EN
   // Count value seen on the last permitted ACCESS cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   logic [7:0]        cnt_q, cnt_d;
   logic              resp_err_q, resp_err_d;
`endif

   // Next-state and registered-output computation for the request/access/release sequence.
   always_comb begin
      state_d      = state_q;
      mem_en_d     = mem_en_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_valid_d = 1'b0;
`ifdef MEMORY_MASTER_TIMEOUT_EN
      cnt_d        = cnt_q;
      resp_err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d        = req_write;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               mem_en_d    = 1'b1;
               mem_read_d  = !req_write;
               mem_write_d = req_write;
`ifdef MEMORY_MASTER_TIMEOUT_EN
               cnt_d       = 8'd0;
`endif
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // mem_ready is checked first so a late ready on the timeout cycle still completes.
            if (mem_ready) begin
               if (!op_q) begin
                  rdata_d = mem_rdata;
               end
               mem_en_d     = 1'b0;
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = RELEASE;
            end
`ifdef MEMORY_MASTER_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LAST) begin
               mem_en_d     = 1'b0;
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               state_d      = RELEASE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RELEASE: begin
            // One disabled cycle lets the memory clear its ready counter.
            state_d = IDLE;
         end
         default: begin
            mem_en_d    = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_en_q     <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         op_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
`ifdef MEMORY_MASTER_TIMEOUT_EN
         cnt_q        <= 8'd0;
         resp_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mem_en_q     <= mem_en_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
`ifdef MEMORY_MASTER_TIMEOUT_EN
         cnt_q        <= cnt_d;
         resp_err_q   <= resp_err_d;
`endif
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign mem_en      = mem_en_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = rdata_q;
`ifdef MEMORY_MASTER_TIMEOUT_EN
   assign resp_err    = resp_err_q;
`else
   assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_memory_master.sv
// Bench for memory_master: RAM model with 2-cycle ready, vector table, scoreboard and corner sequences.
module tb_memory_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_write;
   logic [7:0] req_addr, req_wdata;
   logic       resp_valid, resp_err, busy;
   logic [7:0] resp_rdata;
   logic       mem_en, mem_read, mem_write, mem_ready;
   logic [7:0] mem_address, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   memory_master dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
      .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // RAM model: counts enabled edges, ready one edge after the count leaves 0; writes on every enabled edge.
   logic [7:0] ram [0:127];
   logic [1:0] ram_cnt = 2'd0;
   logic       ram_ready = 1'b0;
   logic [7:0] ram_out = 8'h00;
   logic       stub = 1'b0;
   assign mem_ready = ram_ready & ~stub;
   assign mem_rdata = ram_out;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_write) ram[mem_address[6:0]] <= mem_wdata;
         if (ram_cnt != 2'd3) ram_cnt <= ram_cnt + 2'd1;
         ram_ready <= (ram_cnt != 2'd0);
         ram_out   <= mem_read ? ram[mem_address[6:0]] : 8'hxx;
      end else begin
         ram_cnt   <= 2'd0;
         ram_ready <= 1'b0;
         ram_out   <= 8'hxx;
      end
   end

   // Scoreboard: requests captured at acceptance, resolved against a shadow memory at the response.
   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wd;
      logic       to;
   } sb_t;
   sb_t        sb_q[$];
   int         acc_q[$];
   logic [7:0] shadow [0:127];
   logic [7:0] last_rd = 8'h00;
   logic       expect_to = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (!reset && req_valid && req_ready) begin
         sb_q.push_back('{req_write, req_addr, req_wdata, expect_to});
         acc_q.push_back(cyc);
         chk("en_low_before_accept", {31'd0, mem_en}, 32'd0);
      end
   end

   always @(negedge clk) begin
      sb_t        it;
      logic [7:0] exp_rd;
      chk("rw_protocol", {31'd0, !(mem_read && mem_write) && (mem_en || (!mem_read && !mem_write))}, 32'd1);
      if (reset) begin
         sb_q.delete();
         last_rd = 8'h00;
      end else if (resp_valid) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
         end else begin
            it = sb_q.pop_front();
            if (it.to) begin
               exp_rd = last_rd;
            end else if (it.wr) begin
               shadow[it.addr[6:0]] = it.wd;
               exp_rd = last_rd;
            end else begin
               last_rd = shadow[it.addr[6:0]];
               exp_rd  = last_rd;
            end
            chk("sb_rdata", {24'd0, resp_rdata}, {24'd0, exp_rd});
            chk("sb_err", {31'd0, resp_err}, {31'd0, it.to});
         end
      end
   end

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wd;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!req_ready && n < 30) begin
         tick();
         n++;
      end
      chk(nm, {31'd0, req_ready}, 32'd1);
   endtask

   // One table transaction with every phase of the fixed 5-cycle timing checked.
   task automatic run_vec(input vec_t v);
      wait_ready("vec_ready");
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wd;
      tick(); // E0
      req_valid = 1'b0;
      chk("e0_mem_en", {31'd0, mem_en}, 32'd1);
      chk("e0_mem_read", {31'd0, mem_read}, {31'd0, !v.wr});
      chk("e0_mem_write", {31'd0, mem_write}, {31'd0, v.wr});
      chk("e0_mem_address", {24'd0, mem_address}, {24'd0, v.addr});
      if (v.wr) chk("e0_mem_wdata", {24'd0, mem_wdata}, {24'd0, v.wd});
      chk("e0_req_ready", {31'd0, req_ready}, 32'd0);
      tick(); // E1
      chk("e1_mem_en", {31'd0, mem_en}, 32'd1);
      tick(); // E2
      chk("e2_mem_en", {31'd0, mem_en}, 32'd1);
      chk("e2_resp_valid", {31'd0, resp_valid}, 32'd0);
      tick(); // E3
      chk("e3_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("e3_resp_rdata", {24'd0, resp_rdata}, {24'd0, v.exp_rd});
      chk("e3_resp_err", {31'd0, resp_err}, 32'd0);
      chk("e3_mem_en", {31'd0, mem_en}, 32'd0);
      chk("e3_busy", {31'd0, busy}, 32'd1);
      tick(); // E4
      chk("e4_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("e4_req_ready", {31'd0, req_ready}, 32'd1);
      chk("e4_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      for (int i = 0; i < 128; i++) begin
         ram[i]    = 8'(i * 5);
         shadow[i] = 8'(i * 5);
      end
      vecs[0] = '{1'b0, 8'd1,   8'h00, 8'd5};
      vecs[1] = '{1'b1, 8'd20,  8'hA5, 8'd5};
      vecs[2] = '{1'b0, 8'd20,  8'h00, 8'hA5};
      vecs[3] = '{1'b0, 8'd3,   8'h00, 8'h0F};
      vecs[4] = '{1'b1, 8'd127, 8'h3C, 8'h0F};
      vecs[5] = '{1'b0, 8'd127, 8'h00, 8'h3C};
      vecs[6] = '{1'b0, 8'h82,  8'h00, 8'h0A};
      vecs[7] = '{1'b1, 8'h85,  8'h77, 8'h0A};
      vecs[8] = '{1'b0, 8'd5,   8'h00, 8'h77};
      vecs[9] = '{1'b0, 8'd0,   8'h00, 8'h00};

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mem_ctl", {29'd0, mem_en, mem_read, mem_write}, 32'd0);
      chk("rst_mem_addr_data", {16'd0, mem_address, mem_wdata}, 32'd0);
      chk("rst_resp", {23'd0, resp_valid, resp_err, resp_rdata}, 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back loads with req_valid held high: acceptances must be 5 cycles apart.
      wait_ready("b2b_ready");
      acc_q.delete();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd1;
      repeat (16) tick();
      req_valid = 1'b0;
      repeat (6) tick();
      chk("b2b_accept_count", acc_q.size(), 32'd4);
      for (int i = 1; i < acc_q.size(); i++) chk("b2b_spacing", acc_q[i] - acc_q[i-1], 32'd5);

`ifdef MEMORY_MASTER_TIMEOUT_EN
      // Stubbed memory: abort with resp_err after 15 ACCESS cycles, rdata unchanged.
      wait_ready("to_ready");
      stub = 1'b1; expect_to = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
      tick(); // E0
      req_valid = 1'b0; expect_to = 1'b0;
      n = 0;
      while (!resp_valid && n < 40) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 32'd15);
      chk("to_err", {31'd0, resp_err}, 32'd1);
      chk("to_rdata_held", {24'd0, resp_rdata}, 32'd5);
      chk("to_mem_en", {31'd0, mem_en}, 32'd0);
      tick();
      chk("to_idle", {31'd0, req_ready}, 32'd1);
      stub = 1'b0;

      // Ready arriving on the last permitted cycle wins over the timeout.
      wait_ready("tie_ready");
      stub = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20;
      tick(); // E0
      req_valid = 1'b0;
      bad = 0;
      repeat (14) begin
         tick();
         if (resp_valid) bad++;
      end
      chk("tie_no_early_resp", bad, 32'd0);
      stub = 1'b0;
      tick();
      chk("tie_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("tie_err", {31'd0, resp_err}, 32'd0);
      chk("tie_rdata", {24'd0, resp_rdata}, 32'hA5);
      tick();
`else
      // Without the timeout an unresponsive memory stalls the block indefinitely.
      wait_ready("stall_ready");
      stub = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20;
      tick();
      req_valid = 1'b0;
      bad = 0;
      repeat (40) begin
         tick();
         if (resp_valid || !busy || !mem_en) bad++;
      end
      chk("stall_holds", bad, 32'd0);
      stub = 1'b0;
      n = 0;
      while (!resp_valid && n < 6) begin
         tick();
         n++;
      end
      chk("stall_release_cycles", n, 32'd1);
      chk("stall_rdata", {24'd0, resp_rdata}, 32'hA5);
      chk("stall_err", {31'd0, resp_err}, 32'd0);
      tick();
`endif

      // One-cycle reset sampled at E2 of a load: abort silently, back to IDLE.
      wait_ready("rst_mid_ready");
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
      tick(); // E0
      req_valid = 1'b0;
      tick(); // E1
      reset = 1'b1;
      tick(); // E2
      reset = 1'b0;
      chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mid_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_mid_rdata", {24'd0, resp_rdata}, 32'd0);
      bad = 0;
      repeat (6) begin
         tick();
         if (resp_valid) bad++;
      end
      chk("rst_mid_no_resp", bad, 32'd0);

      // Fresh load after the aborted one still works.
      run_vec('{1'b0, 8'd1, 8'h00, 8'd5});
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
